// File: rtl/ascon_pack.sv
// Shared state encoding and round-index constants for the ASCON mode controller.
package ascon_pack;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    WAIT_AD = 3'd2,
    AD      = 3'd3,
    WAIT_PT = 3'd4,
    PT      = 3'd5,
    FINAL   = 3'd6,
    END     = 3'd7
  } type_fsm_state;

  localparam logic [3:0] ROUND_PA_FIRST = 4'd0;
  localparam logic [3:0] ROUND_PB_FIRST = 4'd4;
  localparam logic [3:0] ROUND_LAST     = 4'd11;

endpackage

// File: rtl/round_counter.sv
// 4-bit round index with synchronous load, saturating increment and last-round flag.
module round_counter
  import ascon_pack::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       enable,
  output logic [3:0] round,
  output logic       last
);

  logic [3:0] count_r;

  // Load has priority; increment stops at the last round so the index never passes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= 4'd0;
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != ROUND_LAST)) begin
      count_r <= count_r + 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign round = count_r;
  assign last  = (count_r == ROUND_LAST);

endmodule

// File: rtl/ascon_fsm.sv
// ASCON-128a encryption controller: sequences init, associated data, plaintext blocks and finalisation.
module ascon_fsm
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] block_count_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       input_mode_o,
  output logic       enable_o,
  output logic       en_xor_begin_data_o,
  output logic       en_xor_begin_key_o,
  output logic       bypass_xor_end_o,
  output logic       mode_xor_key_o,
  output logic       en_reg_cipher_o,
  output logic       en_reg_tag_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       cipher_valid_o,
  output logic       done_o
);

  type_fsm_state state_r, next_state_s;
  logic [7:0] block_cnt_r;
  logic       busy_r, cipher_valid_r;

  logic       data_ready_s, input_mode_s, enable_s, xor_data_s, xor_key_s;
  logic       bypass_s, mode_key_s, reg_cipher_s, reg_tag_s, done_s;
  logic       rc_load_s, rc_enable_s, rc_last_s, blk_load_s, blk_dec_s;
  logic [3:0] rc_value_s, round_s;

  round_counter u_round_counter (
    .clock      (clock_i),
    .reset      (reset_i),
    .load       (rc_load_s),
    .load_value (rc_value_s),
    .enable     (rc_enable_s),
    .round      (round_s),
    .last       (rc_last_s)
  );

  // State register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and datapath control decode; the counter is preloaded with the next phase's first round.
  always_comb begin
    next_state_s = state_r;
    data_ready_s = 1'b0;
    input_mode_s = 1'b1;
    enable_s     = 1'b0;
    xor_data_s   = 1'b0;
    xor_key_s    = 1'b0;
    bypass_s     = 1'b1;
    mode_key_s   = 1'b0;
    reg_cipher_s = 1'b0;
    reg_tag_s    = 1'b0;
    done_s       = 1'b0;
    rc_load_s    = 1'b0;
    rc_value_s   = ROUND_PA_FIRST;
    rc_enable_s  = 1'b0;
    blk_load_s   = 1'b0;
    blk_dec_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          next_state_s = INIT;
          rc_load_s    = 1'b1;
          rc_value_s   = ROUND_PA_FIRST;
          blk_load_s   = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      INIT: begin
        enable_s     = 1'b1;
        input_mode_s = (round_s != ROUND_PA_FIRST);
        if (rc_last_s) begin
          bypass_s     = 1'b0;
          mode_key_s   = 1'b1;
          rc_load_s    = 1'b1;
          rc_value_s   = ROUND_PB_FIRST;
          next_state_s = WAIT_AD;
        end else begin
          rc_enable_s = 1'b1;
        end
      end
      WAIT_AD: begin
        data_ready_s = 1'b1;
        if (data_valid_i) begin
          xor_data_s   = 1'b1;
          enable_s     = 1'b1;
          rc_enable_s  = 1'b1;
          next_state_s = AD;
        end else begin
          next_state_s = WAIT_AD;
        end
      end
      AD: begin
        enable_s = 1'b1;
        if (rc_last_s) begin
          bypass_s     = 1'b0;
          rc_load_s    = 1'b1;
          rc_value_s   = (block_cnt_r > 8'd1) ? ROUND_PB_FIRST : ROUND_PA_FIRST;
          next_state_s = WAIT_PT;
        end else begin
          rc_enable_s = 1'b1;
        end
      end
      WAIT_PT: begin
        data_ready_s = 1'b1;
        if (data_valid_i) begin
          xor_data_s   = 1'b1;
          reg_cipher_s = 1'b1;
          enable_s     = 1'b1;
          rc_enable_s  = 1'b1;
          if (block_cnt_r > 8'd1) begin
            next_state_s = PT;
          end else begin
            xor_key_s    = 1'b1;
            next_state_s = FINAL;
          end
        end else begin
          next_state_s = WAIT_PT;
        end
      end
      PT: begin
        enable_s = 1'b1;
        if (rc_last_s) begin
          blk_dec_s    = 1'b1;
          rc_load_s    = 1'b1;
          // Counter is decremented this cycle, so compare against the pre-decrement value.
          rc_value_s   = (block_cnt_r > 8'd2) ? ROUND_PB_FIRST : ROUND_PA_FIRST;
          next_state_s = WAIT_PT;
        end else begin
          rc_enable_s = 1'b1;
        end
      end
      FINAL: begin
        enable_s = 1'b1;
        if (rc_last_s) begin
          bypass_s     = 1'b0;
          mode_key_s   = 1'b1;
          rc_load_s    = 1'b1;
          rc_value_s   = ROUND_PA_FIRST;
          next_state_s = END;
        end else begin
          rc_enable_s = 1'b1;
        end
      end
      END: begin
        reg_tag_s    = 1'b1;
        done_s       = 1'b1;
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Remaining-block counter; a request for zero blocks runs as one.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      block_cnt_r <= 8'd0;
    end else if (blk_load_s) begin
      block_cnt_r <= (block_count_i == 8'd0) ? 8'd1 : block_count_i;
    end else if (blk_dec_s) begin
      block_cnt_r <= block_cnt_r - 8'd1;
    end else begin
      block_cnt_r <= block_cnt_r;
    end
  end

  // Busy spans accepted start through the done cycle; cipher-valid trails the cipher register load.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      busy_r         <= 1'b0;
      cipher_valid_r <= 1'b0;
    end else begin
      cipher_valid_r <= reg_cipher_s;
      if (blk_load_s) begin
        busy_r <= 1'b1;
      end else if (done_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  assign data_ready_o        = data_ready_s;
  assign input_mode_o        = input_mode_s;
  assign enable_o            = enable_s;
  assign en_xor_begin_data_o = xor_data_s;
  assign en_xor_begin_key_o  = xor_key_s;
  assign bypass_xor_end_o    = bypass_s;
  assign mode_xor_key_o      = mode_key_s;
  assign en_reg_cipher_o     = reg_cipher_s;
  assign en_reg_tag_o        = reg_tag_s;
  assign round_o             = round_s;
  assign busy_o              = busy_r;
  assign cipher_valid_o      = cipher_valid_r;
  assign done_o              = done_s;

endmodule

// File: tb/tb_ascon_fsm.sv
// Cycle-accurate scoreboard bench for ascon_fsm: expected control traces are queued with the stimulus.
module tb_ascon_fsm;

  // Field order: rdy en im xbd xbk byp mxk rc rt cv done busy | round
  typedef logic [15:0] ctl_t;
  typedef struct packed {
    logic start;
    logic valid;
    ctl_t exp;
  } step_t;

  localparam logic [11:0] IDLE_F = 12'b001001000000;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic [7:0] block_count_i;
  logic       data_valid_i;
  logic       data_ready_o, input_mode_o, enable_o, en_xor_begin_data_o, en_xor_begin_key_o;
  logic       bypass_xor_end_o, mode_xor_key_o, en_reg_cipher_o, en_reg_tag_o;
  logic [3:0] round_o;
  logic       busy_o, cipher_valid_o, done_o;

  step_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cv_cnt;

  ascon_fsm dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .start_i             (start_i),
    .block_count_i       (block_count_i),
    .data_valid_i        (data_valid_i),
    .data_ready_o        (data_ready_o),
    .input_mode_o        (input_mode_o),
    .enable_o            (enable_o),
    .en_xor_begin_data_o (en_xor_begin_data_o),
    .en_xor_begin_key_o  (en_xor_begin_key_o),
    .bypass_xor_end_o    (bypass_xor_end_o),
    .mode_xor_key_o      (mode_xor_key_o),
    .en_reg_cipher_o     (en_reg_cipher_o),
    .en_reg_tag_o        (en_reg_tag_o),
    .round_o             (round_o),
    .busy_o              (busy_o),
    .cipher_valid_o      (cipher_valid_o),
    .done_o              (done_o)
  );

  always #5 clock_i = ~clock_i;

  function automatic ctl_t mk(input logic [11:0] f, input int rnd);
    logic [3:0] r4;
    r4 = rnd[3:0];
    return {f, r4};
  endfunction

  function automatic ctl_t get_obs();
    return {data_ready_o, enable_o, input_mode_o, en_xor_begin_data_o, en_xor_begin_key_o,
            bypass_xor_end_o, mode_xor_key_o, en_reg_cipher_o, en_reg_tag_o, cipher_valid_o,
            done_o, busy_o, round_o};
  endfunction

  task automatic push(input logic st, input logic vld, input ctl_t e);
    step_t s;
    s.start = st;
    s.valid = vld;
    s.exp   = e;
    exp_q.push_back(s);
  endtask

  task automatic check(input string tag, input int idx, input ctl_t e);
    ctl_t obs;
    obs = get_obs();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, idx, obs, e);
    end
  endtask

  // Expected trace of one full encryption, written from the controller's behavioural description.
  task automatic gen_op(input int nblk, input int stall, input logic poke);
    int n;
    int fr;
    n = (nblk == 0) ? 1 : nblk;
    push(1'b1, 1'b1, mk(IDLE_F, 0));
    for (int r = 0; r < 12; r++)
      push(1'b0, 1'b1, mk({1'b0, 1'b1, (r != 0), 2'b00, (r != 11), (r == 11), 5'b00001}, r));
    push(1'b0, 1'b1, mk(12'b111101000001, 4));
    for (int r = 5; r < 12; r++)
      push(poke, 1'b1, mk({2'b01, 1'b1, 2'b00, (r != 11), 1'b0, 5'b00001}, r));
    for (int b = 1; b <= n; b++) begin
      fr = (b < n) ? 4 : 0;
      if (b == 1) begin
        for (int s = 0; s < stall; s++)
          push(1'b0, 1'b0, mk(12'b101001000001, fr));
      end
      push(1'b0, 1'b1, mk({4'b1111, (b == n), 1'b1, 1'b0, 1'b1, 3'b000, 1'b1}, fr));
      for (int r = fr + 1; r < 12; r++)
        push(1'b0, 1'b1, mk({2'b01, 1'b1, 2'b00, ((b < n) || (r != 11)), ((b == n) && (r == 11)),
                             2'b00, (r == fr + 1), 2'b01}, r));
    end
    push(1'b0, 1'b1, mk(12'b001001001011, 0));
    push(1'b0, 1'b1, mk(IDLE_F, 0));
  endtask

  // Drive each queued step after a falling edge and compare once the outputs settle.
  task automatic run_q(input string tag, input int limit, output int cvs);
    step_t s;
    int k;
    k = 0;
    cvs = 0;
    while ((exp_q.size() > 0) && (k < limit)) begin
      s = exp_q.pop_front();
      @(negedge clock_i);
      start_i      = s.start;
      data_valid_i = s.valid;
      #1;
      check(tag, k, s.exp);
      if (cipher_valid_o === 1'b1) cvs++;
      k++;
    end
  endtask

  initial begin
    reset_i       = 1'b1;
    start_i       = 1'b0;
    block_count_i = 8'd0;
    data_valid_i  = 1'b0;
    repeat (2) @(negedge clock_i);
    #1;
    check("reset_state", 0, mk(IDLE_F, 0));
    @(negedge clock_i);
    reset_i = 1'b0;

    block_count_i = 8'd1;
    gen_op(1, 0, 1'b0);
    run_q("bc1", 1000, cv_cnt);

    block_count_i = 8'd3;
    gen_op(3, 0, 1'b0);
    run_q("bc3", 1000, cv_cnt);
    checks++;
    assert (cv_cnt === 3) else begin
      failures++;
      $error("FAIL bc3_cipher_pulses observed=%0d expected=3", cv_cnt);
    end

    block_count_i = 8'd2;
    gen_op(2, 5, 1'b0);
    run_q("stall", 1000, cv_cnt);

    block_count_i = 8'd0;
    gen_op(0, 0, 1'b0);
    run_q("bc0", 1000, cv_cnt);

    block_count_i = 8'd1;
    gen_op(1, 0, 1'b1);
    run_q("start_in_ad", 1000, cv_cnt);

    // Abort in PT round 6 of the first block.
    block_count_i = 8'd3;
    gen_op(3, 0, 1'b0);
    run_q("pre_abort", 24, cv_cnt);
    exp_q.delete();
    reset_i = 1'b1;
    #1;
    check("abort_async", 0, mk(IDLE_F, 0));
    for (int i = 1; i < 4; i++) begin
      @(negedge clock_i);
      #1;
      check("abort_hold", i, mk(IDLE_F, 0));
    end
    @(negedge clock_i);
    reset_i = 1'b0;
    start_i = 1'b0;

    block_count_i = 8'd2;
    gen_op(2, 0, 1'b0);
    run_q("after_abort", 1000, cv_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascon_fsm.md
ASCON_FSM -- requirements
Module: ascon_fsm

Interface
REQ-001 The block SHALL have no parameters; round bounds SHALL come from package constants (REQ-030).
REQ-002 clock_i  in  1  single clock, rising-edge.
REQ-003 reset_i  in  1  asynchronous, active-high reset.
REQ-004 start_i  in  1  one-cycle request to start an encryption; sampled only in IDLE.
REQ-005 block_count_i  in  8  number of 128-bit plaintext blocks; latched on accepted start; 0 SHALL be treated as 1.
REQ-006 data_valid_i  in  1  data_i on the datapath holds a valid AD or plaintext block.
REQ-007 data_ready_o  out  1  controller is waiting for a block; transfer occurs when data_valid_i and data_ready_o are both 1.
REQ-008 input_mode_o, enable_o, en_xor_begin_data_o, en_xor_begin_key_o, bypass_xor_end_o, mode_xor_key_o, en_reg_cipher_o, en_reg_tag_o  out  1 each  datapath controls.
REQ-009 round_o  out  4  round-constant index to the datapath.
REQ-010 busy_o  out  1  high from accepted start until done_o.
REQ-011 cipher_valid_o  out  1  one-cycle pulse: cipher register updated.
REQ-012 done_o  out  1  one-cycle pulse: tag register updated, operation complete.

Function
REQ-013 States SHALL be IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, END.
REQ-014 IDLE: data_ready_o=0, enable_o=0; start_i=1 -> INIT, round counter=0, block counter=block_count_i (0->1).
REQ-015 INIT: 12 cycles, round_o 0..11, enable_o=1; input_mode_o=0 on round 0 only (external IV||K||N), 1 otherwise; on round 11 bypass_xor_end_o=0, mode_xor_key_o=1 (key XOR at end); then -> WAIT_AD.
REQ-016 WAIT_AD: data_ready_o=1, enable_o=0; on transfer the same cycle SHALL be AD round 4 (en_xor_begin_data_o=1, enable_o=1), state -> AD.
REQ-017 AD: rounds 4..11 total 8 cycles including transfer cycle; on round 11 bypass_xor_end_o=0, mode_xor_key_o=0 (domain-separation bit); then -> WAIT_PT.
REQ-018 WAIT_PT: data_ready_o=1; on transfer en_xor_begin_data_o=1, en_reg_cipher_o=1, enable_o=1 in that cycle; block counter>1 -> PT starting round 4; block counter=1 -> FINAL starting round 0 with en_xor_begin_key_o=1 also asserted.
REQ-019 PT: rounds through 11, bypass_xor_end_o=1 throughout; after round 11 decrement block counter, -> WAIT_PT.
REQ-020 FINAL: rounds 0..11 (12 cycles incl. transfer); on round 11 bypass_xor_end_o=0, mode_xor_key_o=1; -> END.
REQ-021 END: en_reg_tag_o=1 for one cycle, done_o=1 same cycle; -> IDLE; busy_o falls next cycle.
REQ-022 cipher_valid_o SHALL pulse in the cycle after en_reg_cipher_o.
REQ-023 bypass_xor_end_o SHALL be 1 whenever not specified 0 above; en_xor_begin_* SHALL be 0 on all non-first rounds.
REQ-024 start_i while busy_o=1 SHALL be ignored; data_valid_i while data_ready_o=0 SHALL be ignored.
REQ-025 Round counter SHALL never exceed 11; 11 is the last-round condition for every phase.
REQ-026 Outside round cycles enable_o=0 so the datapath state holds while waiting.

Reset
REQ-027 reset_i=1 SHALL force IDLE, counters 0, all outputs 0 except bypass_xor_end_o=1, input_mode_o=1, asynchronously.
REQ-028 Reset mid-operation SHALL abort without done_o or cipher_valid_o pulse; first start after release begins at INIT.

Structure
REQ-029 State enum type_fsm_state SHALL live in ascon_pack.
REQ-030 Constants ROUND_PA_FIRST=0, ROUND_PB_FIRST=4, ROUND_LAST=11 SHALL live in ascon_pack.
REQ-031 One sub-module round_counter (4-bit, load value, enable, last flag) SHALL be instantiated; FSM next-state/output logic stays in ascon_fsm.

Verification
REQ-032 Reset then start_i with block_count_i=1, data_valid_i always 1 -> INIT 12 cycles, AD 8 cycles, FINAL 12 cycles, done_o one cycle after FINAL round 11; 33 cycles start-to-done.
REQ-033 block_count_i=3 -> exactly 3 cipher_valid_o pulses, rounds 4..11 for blocks 1-2, 0..11 for block 3 with en_xor_begin_key_o=1 on its first cycle.
REQ-034 data_valid_i held 0 for 5 cycles in WAIT_PT -> enable_o=0 and round_o constant for those 5 cycles, data_ready_o=1 throughout.
REQ-035 block_count_i=0 -> identical trace to block_count_i=1.
REQ-036 reset_i asserted in PT round 6 -> all outputs to reset values immediately, no done_o; new start completes normally.
REQ-037 start_i pulsed during AD -> no effect on trace or busy_o; full run vs. ASCON-128a known-answer vector through permutation datapath -> tag and cipher match.
